alu_operand_stage: RTL and testbench

//   ID/EX pipeline register directly upstream of the 16-bit ALU. Captures decoded

---
 rtl/alu_operand_stage.sv | 145 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
`timescale 1ns/1ps
// ID/EX register in front of the 16-bit ALU: captures operands and stalls on RAW hazards.
// Define ALU_FWD_EN for EX/MEM/WB forwarding; without it any pending writer match stalls.
module alu_operand_stage #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned CTRL_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_rt_used,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  id_use_imm,
  input  logic [CTRL_W-1:0]     id_alu_ctrl,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0]     mem_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  freeze,
  input  logic                  flush,
  output logic                  id_stall,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_in1,
  output logic [DATA_W-1:0]     ex_in2,
  output logic [CTRL_W-1:0]     ex_alu_ctrl,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read
);

  logic                  valid_q, reg_write_q, mem_read_q;
  logic [DATA_W-1:0]     in1_q, in2_q, store_q;
  logic [CTRL_W-1:0]     ctrl_q;
  logic [REG_ADDR_W-1:0] rd_q;

  logic              ex_wr, mem_wr, wb_wr;
  logic              rs_ex, rt_ex;
  logic              hazard;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  assign ex_wr  = valid_q & reg_write_q & (rd_q != '0);
  assign mem_wr = mem_reg_write & (mem_rd_addr != '0);
  assign wb_wr  = wb_reg_write & (wb_rd_addr != '0);
  assign rs_ex  = ex_wr & (rd_q == id_rs_addr);
  assign rt_ex  = ex_wr & id_rt_used & (rd_q == id_rt_addr);

`ifdef ALU_FWD_EN
  logic ex_fwd;

  // Loads in EX have no result yet, so they are excluded from forwarding and stall instead.
  assign ex_fwd = valid_q & reg_write_q & ~mem_read_q;
  assign hazard = mem_read_q & (rs_ex | rt_ex);

  always_comb begin
    fwd_rs = id_rs_data;
    if (id_rs_addr == '0)                              fwd_rs = '0;
    else if (ex_fwd && rd_q == id_rs_addr)             fwd_rs = alu_result;
    else if (mem_wr && mem_rd_addr == id_rs_addr)      fwd_rs = mem_result;
    else if (wb_wr && wb_rd_addr == id_rs_addr)        fwd_rs = wb_data;
  end

  always_comb begin
    fwd_rt = id_rt_data;
    if (id_rt_addr == '0)                              fwd_rt = '0;
    else if (ex_fwd && rd_q == id_rt_addr)             fwd_rt = alu_result;
    else if (mem_wr && mem_rd_addr == id_rt_addr)      fwd_rt = mem_result;
    else if (wb_wr && wb_rd_addr == id_rt_addr)        fwd_rt = wb_data;
  end
`else
  logic rs_mem, rt_mem, rs_wb, rt_wb;
  logic unused_fwd_data;

  assign rs_mem = mem_wr & (mem_rd_addr == id_rs_addr);
  assign rt_mem = mem_wr & id_rt_used & (mem_rd_addr == id_rt_addr);
  assign rs_wb  = wb_wr & (wb_rd_addr == id_rs_addr);
  assign rt_wb  = wb_wr & id_rt_used & (wb_rd_addr == id_rt_addr);
  assign hazard = rs_ex | rt_ex | rs_mem | rt_mem | rs_wb | rt_wb;

  assign fwd_rs = (id_rs_addr == '0) ? '0 : id_rs_data;
  assign fwd_rt = (id_rt_addr == '0) ? '0 : id_rt_data;

  assign unused_fwd_data = ^{alu_result, mem_result, wb_data};
`endif

  always_comb begin
    id_stall = 1'b0;
    if (rst_n && !flush) begin
      id_stall = freeze | (id_valid & hazard);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      store_q     <= '0;
      ctrl_q      <= '0;
      rd_q        <= '0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (!freeze) begin
      if (id_valid && hazard) begin
        valid_q     <= 1'b0;
        reg_write_q <= 1'b0;
        mem_read_q  <= 1'b0;
      end else begin
        valid_q     <= id_valid;
        reg_write_q <= id_valid & id_reg_write;
        mem_read_q  <= id_valid & id_mem_read;
        in1_q       <= fwd_rs;
        in2_q       <= id_use_imm ? id_imm : fwd_rt;
        store_q     <= fwd_rt;
        ctrl_q      <= id_alu_ctrl;
        rd_q        <= id_rd_addr;
      end
    end
  end

  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_in1        = in1_q;
  assign ex_in2        = in2_q;
  assign ex_store_data = store_q;
  assign ex_alu_ctrl   = ctrl_q;
  assign ex_rd_addr    = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
`timescale 1ns/1ps
// Bench for alu_operand_stage: directed vector table, then random stimulus against a model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, id_rt_used, id_use_imm, id_reg_write, id_mem_read;
  logic [2:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_alu_ctrl;
  logic [15:0] id_rs_data, id_rt_data, id_imm, alu_result;
  logic        mem_reg_write, wb_reg_write, freeze, flush;
  logic [2:0]  mem_rd_addr, wb_rd_addr;
  logic [15:0] mem_result, wb_data;
  logic        id_stall, ex_valid, ex_reg_write, ex_mem_read;
  logic [15:0] ex_in1, ex_in2, ex_store_data;
  logic [2:0]  ex_alu_ctrl, ex_rd_addr;

  int checks = 0;
  int errors = 0;

  alu_operand_stage #(.DATA_W(16), .REG_ADDR_W(3), .CTRL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_alu_ctrl(id_alu_ctrl), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .alu_result(alu_result), .mem_reg_write(mem_reg_write),
    .mem_rd_addr(mem_rd_addr), .mem_result(mem_result), .wb_reg_write(wb_reg_write),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .freeze(freeze), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, id_valid, rt_used, use_imm, reg_write, mem_read;
    logic [2:0]  rs, rt, rd, ctrl;
    logic [15:0] rs_data, rt_data, imm, alu_result;
    logic        mem_rw;
    logic [2:0]  mem_rd;
    logic [15:0] mem_res;
    logic        wb_rw;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        freeze, flush;
    logic        exp_stall, exp_valid, exp_rw, chk_in1;
    logic [15:0] exp_in1;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t nop();
    vec_t v;
    v = '{default: '0};
    v.rst_n = 1'b1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; id_valid = v.id_valid; id_rt_used = v.rt_used; id_use_imm = v.use_imm;
    id_reg_write = v.reg_write; id_mem_read = v.mem_read; id_rs_addr = v.rs;
    id_rt_addr = v.rt; id_rd_addr = v.rd; id_alu_ctrl = v.ctrl; id_rs_data = v.rs_data;
    id_rt_data = v.rt_data; id_imm = v.imm; alu_result = v.alu_result;
    mem_reg_write = v.mem_rw; mem_rd_addr = v.mem_rd; mem_result = v.mem_res;
    wb_reg_write = v.wb_rw; wb_rd_addr = v.wb_rd; wb_data = v.wb_data;
    freeze = v.freeze; flush = v.flush;
  endtask

  // Helpers to append table rows compactly.
  function automatic vec_t instr(input logic [2:0] rs, input logic [15:0] rs_data,
                                 input logic [2:0] rd, input logic rw, input logic mr);
    vec_t v;
    v = nop();
    v.id_valid = 1'b1; v.rs = rs; v.rs_data = rs_data; v.rt = 3'd3; v.rt_used = 1'b1;
    v.rd = rd; v.reg_write = rw; v.mem_read = mr;
    return v;
  endfunction

  task automatic expect_row(input vec_t v, input logic st, input logic vl, input logic rw,
                            input logic ci, input logic [15:0] in1);
    v.exp_stall = st; v.exp_valid = vl; v.exp_rw = rw; v.chk_in1 = ci; v.exp_in1 = in1;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    vec_t v;
    v = instr(3'd1, 16'h1234, 3'd1, 1'b1, 1'b0);
    v.rst_n = 1'b0;
    expect_row(v, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    expect_row(v, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
`ifdef ALU_FWD_EN
    expect_row(instr(3'd2, 16'h0003, 3'd1, 1'b1, 1'b0), 1'b0, 1'b1, 1'b1, 1'b1, 16'h0003);
    v = instr(3'd1, 16'h0000, 3'd4, 1'b1, 1'b0); v.alu_result = 16'h0005; v.ctrl = 3'd1;
    expect_row(v, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0005);
    v = instr(3'd4, 16'h0000, 3'd0, 1'b1, 1'b0); v.alu_result = 16'h1111;
    v.mem_rw = 1'b1; v.mem_rd = 3'd4; v.mem_res = 16'h2222;
    v.wb_rw = 1'b1; v.wb_rd = 3'd4; v.wb_data = 16'h3333;
    expect_row(v, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1111);
    v = instr(3'd0, 16'hFFFF, 3'd5, 1'b1, 1'b0); v.alu_result = 16'hFFFF;
    expect_row(v, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    v = instr(3'd6, 16'h0000, 3'd0, 1'b0, 1'b0);
    v.mem_rw = 1'b1; v.mem_rd = 3'd6; v.mem_res = 16'h2222;
    v.wb_rw = 1'b1; v.wb_rd = 3'd6; v.wb_data = 16'h3333;
    expect_row(v, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2222);
    expect_row(instr(3'd0, 16'h0000, 3'd2, 1'b1, 1'b1), 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    v = instr(3'd2, 16'h0000, 3'd1, 1'b1, 1'b0); v.rt = 3'd0;
    expect_row(v, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    v.mem_rw = 1'b1; v.mem_rd = 3'd2; v.mem_res = 16'h00AB;
    expect_row(v, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00AB);
`else
    expect_row(instr(3'd1, 16'h0010, 3'd5, 1'b1, 1'b0), 1'b0, 1'b1, 1'b1, 1'b1, 16'h0010);
    // RAW on r5: writer moves EX -> MEM -> WB, one stall per stage, then the RF value is used.
    v = instr(3'd5, 16'h0000, 3'd2, 1'b1, 1'b0); v.ctrl = 3'd1; v.alu_result = 16'h0030;
    expect_row(v, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    v.mem_rw = 1'b1; v.mem_rd = 3'd5; v.mem_res = 16'h0030;
    expect_row(v, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    v.mem_rw = 1'b0; v.wb_rw = 1'b1; v.wb_rd = 3'd5; v.wb_data = 16'h0030;
    expect_row(v, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    v.wb_rw = 1'b0; v.rs_data = 16'h0030;
    expect_row(v, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0030);
    v = instr(3'd0, 16'hFFFF, 3'd0, 1'b1, 1'b0); v.rt = 3'd0;
    expect_row(v, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    v = instr(3'd1, 16'h00AB, 3'd3, 1'b1, 1'b0); v.rt = 3'd0; v.mem_rw = 1'b1;
    v.alu_result = 16'hFFFF;
    expect_row(v, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00AB);
`endif
    // Freeze holds EX for three cycles, then flush overrides freeze.
    v = instr(3'd3, 16'h5555, 3'd6, 1'b1, 1'b0); v.freeze = 1'b1;
    for (int i = 0; i < 3; i++) expect_row(v, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00AB);
    v.flush = 1'b1;
    expect_row(v, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    v.freeze = 1'b0;
    expect_row(v, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    v = nop(); v.rs = 3'd4; v.wb_rw = 1'b1; v.wb_rd = 3'd4; v.reg_write = 1'b1;
    expect_row(v, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    expect_row(instr(3'd0, 16'h0000, 3'd2, 1'b1, 1'b1), 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    v = instr(3'd2, 16'h00CD, 3'd1, 1'b1, 1'b0);
    expect_row(v, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    v.rst_n = 1'b0; v.freeze = 1'b1;
    expect_row(v, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    v.rst_n = 1'b1; v.freeze = 1'b0;
    expect_row(v, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00CD);
  endtask

  // Reference model state: contents of the EX slot as the rules define it.
  logic        m_valid, m_rw, m_mr;
  logic [2:0]  m_rd, m_ctrl;
  logic [15:0] m_in1, m_in2, m_store;

  function automatic logic [15:0] model_operand(input logic [2:0] src, input logic [15:0] rf);
    logic        en  [3];
    logic [2:0]  rd  [3];
    logic [15:0] val [3];
    if (src == 3'd0) return 16'h0000;
`ifdef ALU_FWD_EN
    en[0] = m_valid && m_rw && !m_mr; rd[0] = m_rd;        val[0] = alu_result;
    en[1] = mem_reg_write;            rd[1] = mem_rd_addr; val[1] = mem_result;
    en[2] = wb_reg_write;             rd[2] = wb_rd_addr;  val[2] = wb_data;
    for (int i = 0; i < 3; i++) if (en[i] && rd[i] == src) return val[i];
`else
    en[0] = 1'b0; rd[0] = 3'd0; val[0] = 16'h0000;
    en[1] = 1'b0; rd[1] = 3'd0; val[1] = 16'h0000;
    en[2] = 1'b0; rd[2] = 3'd0; val[2] = 16'h0000;
`endif
    return rf;
  endfunction

  function automatic logic model_hazard();
    logic       en [3];
    logic [2:0] rd [3];
    logic       h;
    en[0] = m_valid && m_rw; rd[0] = m_rd;
    en[1] = mem_reg_write;   rd[1] = mem_rd_addr;
    en[2] = wb_reg_write;    rd[2] = wb_rd_addr;
`ifdef ALU_FWD_EN
    en[0] = en[0] && m_mr;
    en[1] = 1'b0;
    en[2] = 1'b0;
`endif
    h = 1'b0;
    for (int i = 0; i < 3; i++)
      if (en[i] && rd[i] != 3'd0 && (rd[i] == id_rs_addr || (id_rt_used && rd[i] == id_rt_addr)))
        h = 1'b1;
    return h;
  endfunction

  initial begin
    vec_t        v;
    logic        e_stall, haz;
    logic        n_valid, n_rw, n_mr;
    logic [2:0]  n_rd, n_ctrl;
    logic [15:0] n_in1, n_in2, n_store;

    drive(nop());
    build_table();
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("tbl%0d id_stall", i), id_stall, vecs[i].exp_stall);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d ex_valid", i), ex_valid, vecs[i].exp_valid);
      check($sformatf("tbl%0d ex_reg_write", i), ex_reg_write, vecs[i].exp_rw);
      if (vecs[i].chk_in1) check($sformatf("tbl%0d ex_in1", i), ex_in1, vecs[i].exp_in1);
      if (!vecs[i].rst_n) begin
        check($sformatf("tbl%0d rst ex_in2", i), ex_in2, 0);
        check($sformatf("tbl%0d rst ex_store_data", i), ex_store_data, 0);
        check($sformatf("tbl%0d rst ex_alu_ctrl", i), ex_alu_ctrl, 0);
        check($sformatf("tbl%0d rst ex_rd_addr", i), ex_rd_addr, 0);
        check($sformatf("tbl%0d rst ex_mem_read", i), ex_mem_read, 0);
      end
      @(negedge clk);
    end

    m_valid = 0; m_rw = 0; m_mr = 0; m_rd = 0; m_ctrl = 0; m_in1 = 0; m_in2 = 0; m_store = 0;
    for (int c = 0; c < 3000; c++) begin
      v = nop();
      v.rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      v.id_valid = ($urandom_range(0, 9) != 0);
      v.rs = 3'($urandom_range(0, 7)); v.rt = 3'($urandom_range(0, 7));
      v.rd = 3'($urandom_range(0, 7)); v.ctrl = 3'($urandom_range(0, 7));
      v.rt_used = $urandom_range(0, 1); v.use_imm = $urandom_range(0, 1);
      v.reg_write = ($urandom_range(0, 3) != 0); v.mem_read = ($urandom_range(0, 3) == 0);
      v.rs_data = (v.rs == 3'd0) ? 16'h0000 : 16'($urandom);
      v.rt_data = (v.rt == 3'd0) ? 16'h0000 : 16'($urandom);
      v.imm = 16'($urandom); v.alu_result = 16'($urandom);
      v.mem_rw = $urandom_range(0, 1); v.mem_rd = 3'($urandom_range(0, 7));
      v.mem_res = 16'($urandom);
      v.wb_rw = $urandom_range(0, 1); v.wb_rd = 3'($urandom_range(0, 7));
      v.wb_data = 16'($urandom);
      v.freeze = ($urandom_range(0, 9) == 0); v.flush = ($urandom_range(0, 11) == 0);
      drive(v);
      #1;
      haz = model_hazard();
      e_stall = v.rst_n && !v.flush && (v.freeze || (v.id_valid && haz));
      check("rnd id_stall", id_stall, e_stall);
      n_valid = m_valid; n_rw = m_rw; n_mr = m_mr; n_rd = m_rd; n_ctrl = m_ctrl;
      n_in1 = m_in1; n_in2 = m_in2; n_store = m_store;
      if (!v.rst_n) begin
        n_valid = 0; n_rw = 0; n_mr = 0; n_rd = 0; n_ctrl = 0; n_in1 = 0; n_in2 = 0;
        n_store = 0;
      end else if (v.flush || (!v.freeze && v.id_valid && haz)) begin
        n_valid = 0; n_rw = 0; n_mr = 0;
      end else if (!v.freeze) begin
        n_valid = v.id_valid; n_rw = v.id_valid && v.reg_write;
        n_mr = v.id_valid && v.mem_read; n_rd = v.rd; n_ctrl = v.ctrl;
        n_in1 = model_operand(v.rs, v.rs_data);
        n_store = model_operand(v.rt, v.rt_data);
        n_in2 = v.use_imm ? v.imm : n_store;
      end
      @(posedge clk);
      #1;
      m_valid = n_valid; m_rw = n_rw; m_mr = n_mr; m_rd = n_rd; m_ctrl = n_ctrl;
      m_in1 = n_in1; m_in2 = n_in2; m_store = n_store;
      check("rnd ex_valid", ex_valid, m_valid);
      check("rnd ex_reg_write", ex_reg_write, m_rw);
      check("rnd ex_mem_read", ex_mem_read, m_mr);
      if (m_valid) begin
        check("rnd ex_rd_addr", ex_rd_addr, m_rd);
        check("rnd ex_alu_ctrl", ex_alu_ctrl, m_ctrl);
        check("rnd ex_in1", ex_in1, m_in1);
        check("rnd ex_in2", ex_in2, m_in2);
        check("rnd ex_store_data", ex_store_data, m_store);
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
